reg_sequencer: RTL and testbench
================================

REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 512, giving the width of the data paths.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of WAIT cycles for alu_done.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  command offered.
REQ-006 The block SHALL have port cmd_ready  output  1  block accepts a command this cycle.
REQ-007 The block SHALL have port cmd_op  input  2  operation: 00 WRITE, 01 READ, 10 COMPUTE, 11 CLEAR.
REQ-008 The block SHALL have port cmd_addr  input  2  register index: 0 a, 1 b, 2 s0, 3 s1.
REQ-009 The block SHALL have port cmd_wdata  input  DATA_W  write data for WRITE.
REQ-010 The block SHALL have port we  output  1  register-file write strobe.
REQ-011 The block SHALL have port re  output  1  register-file read strobe.
REQ-012 The block SHALL have port select  output  1  register-file strobe that captures the product halves into s0/s1.
REQ-013 The block SHALL have port add  output  2  register-file address.
REQ-014 The block SHALL have port wdata  output  DATA_W  register-file write data.
REQ-015 The block SHALL have port read_data  input  DATA_W  combinational register-file read data.
REQ-016 The block SHALL have port alu_start  output  1  one-cycle start pulse to the multiplier.
REQ-017 The block SHALL have port alu_done  input  1  multiplier result valid on ldata/hdata.
REQ-018 The block SHALL have port rsp_valid  output  1  response pending.
REQ-019 The block SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-020 The block SHALL have port rsp_data  output  DATA_W  READ result; 0 for other operations.
REQ-021 The block SHALL have port rsp_err  output  1  COMPUTE timed out.

Function
REQ-022 The FSM SHALL have the states IDLE, WRITE, READ, START, WAIT, CAPTURE, CLEAR and RESP.
REQ-023 cmd_ready SHALL be 1 only in IDLE, and the block SHALL accept a command on cmd_valid&&cmd_ready, latching op, addr and wdata.
REQ-024 On acceptance the FSM SHALL go to WRITE, READ, START or CLEAR according to op, in the next cycle.
REQ-025 WRITE SHALL last 1 cycle with we=1, add=addr and wdata=latched data, then go to RESP with rsp_data=0.
REQ-026 READ SHALL last 1 cycle with re=1 and add=addr; rsp_data SHALL load read_data at the closing edge, then the FSM goes to RESP.
REQ-027 START SHALL last 1 cycle with alu_start=1 and SHALL clear the timeout counter; the FSM then goes to WAIT.
REQ-028 In WAIT the counter SHALL increment each cycle; on alu_done the FSM SHALL go to CAPTURE; if the counter equals TIMEOUT-1 without alu_done, the FSM SHALL go to RESP with rsp_err=1.
REQ-029 If alu_done and the timeout occur in the same cycle, alu_done SHALL win (no error).
REQ-030 CAPTURE SHALL last 1 cycle with select=1, then go to RESP with rsp_err=0.
REQ-031 CLEAR SHALL last 4 cycles with we=1, wdata=0 and add=0,1,2,3 in order, then go to RESP.
REQ-032 In RESP, rsp_valid SHALL be 1 with rsp_data/rsp_err held stable; on rsp_ready the FSM SHALL return to IDLE and cmd_ready SHALL rise the next cycle.
REQ-033 we, re and select SHALL be mutually exclusive at all times.
REQ-034 we, re, select and alu_start SHALL be 0 in every state not listed for them, and wdata SHALL be 0 whenever we=0.
REQ-035 All outputs except cmd_ready SHALL be registered.
REQ-036 Back-to-back commands SHALL be separated by at least the RESP cycle; minimum WRITE latency is accept -> rsp_valid = 2 cycles.

Reset
REQ-037 While rst=1, the block SHALL force state=IDLE, we=re=select=alu_start=0, add=0, wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0 and counter=0.
REQ-038 cmd_ready SHALL be 0 during reset and 1 from the first cycle after rst falls.
REQ-039 Reset mid-operation (including within CLEAR or WAIT) SHALL abort the operation with no further strobes; a partial CLEAR is not resumed.

Verification
REQ-040 Directed test: WRITE addr=1 data=0xABCD -> exactly one cycle of we=1, add=1, wdata=0xABCD; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-041 Directed test: READ addr=2 with read_data=0x1234 -> re=1 for one cycle, add=2; rsp_data=0x1234 until rsp_ready.
REQ-042 Directed test: COMPUTE with alu_done 5 cycles after alu_start -> one select pulse; rsp_err=0; no we/re seen.
REQ-043 Directed test: COMPUTE with alu_done never asserted, TIMEOUT=8 -> no select; rsp_valid with rsp_err=1 after 8 WAIT cycles.
REQ-044 Directed test: CLEAR -> we=1 for 4 consecutive cycles with add 0,1,2,3 and wdata=0; rsp_valid held 3 cycles while rsp_ready=0, then IDLE.
REQ-045 Directed test: rst pulsed during the 2nd CLEAR cycle -> all strobes 0 immediately; cmd_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/reg_sequencer_if.sv
// Command, register-file, multiplier and response signals of the register sequencer.
interface reg_sequencer_if #(
   parameter int unsigned DATA_W = 512
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [1:0]        cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              we;
   logic              re;
   logic              select;
   logic [1:0]        add;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] read_data;
   logic              alu_start;
   logic              alu_done;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, read_data, alu_done, rsp_ready,
      output cmd_ready, we, re, select, add, wdata, alu_start, rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, read_data, alu_done, rsp_ready,
      input  cmd_ready, we, re, select, add, wdata, alu_start, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/reg_sequencer.sv
// Sequences WRITE/READ/COMPUTE/CLEAR commands onto a 4-entry register file and a
// multiplier, returning one response per command. Strobes are registered look-ahead.
module reg_sequencer #(
   parameter int unsigned DATA_W  = 512,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   reg_sequencer_if.slave  bus
);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] OP_WRITE   = 2'b00;
   localparam logic [1:0] OP_READ    = 2'b01;
   localparam logic [1:0] OP_COMPUTE = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_START, S_WAIT, S_CAPTURE, S_CLEAR, S_RESP
   } state_t;

   state_t            state, state_nxt;
   logic              we_q, we_nxt;
   logic              re_q, re_nxt;
   logic              sel_q, sel_nxt;
   logic              start_q, start_nxt;
   logic [1:0]        add_q, add_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic              rsp_valid_q, rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_nxt;
   logic              rsp_err_q, rsp_err_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         sel_q       <= 1'b0;
         start_q     <= 1'b0;
         add_q       <= 2'd0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state       <= state_nxt;
         we_q        <= we_nxt;
         re_q        <= re_nxt;
         sel_q       <= sel_nxt;
         start_q     <= start_nxt;
         add_q       <= add_nxt;
         wdata_q     <= wdata_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_data_q  <= rsp_data_nxt;
         rsp_err_q   <= rsp_err_nxt;
         cnt_q       <= cnt_nxt;
      end
   end

   // Next state; each strobe is computed for the state being entered
   always_comb begin
      state_nxt     = state;
      we_nxt        = 1'b0;
      re_nxt        = 1'b0;
      sel_nxt       = 1'b0;
      start_nxt     = 1'b0;
      add_nxt       = add_q;
      wdata_nxt     = '0;
      rsp_valid_nxt = 1'b0;
      rsp_data_nxt  = rsp_data_q;
      rsp_err_nxt   = rsp_err_q;
      cnt_nxt       = cnt_q;

      unique case (state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b0;
               add_nxt      = bus.cmd_addr;
               unique case (bus.cmd_op)
                  OP_WRITE: begin
                     state_nxt = S_WRITE;
                     we_nxt    = 1'b1;
                     wdata_nxt = bus.cmd_wdata;
                  end
                  OP_READ: begin
                     state_nxt = S_READ;
                     re_nxt    = 1'b1;
                  end
                  OP_COMPUTE: begin
                     state_nxt = S_START;
                     start_nxt = 1'b1;
                  end
                  default: begin
                     state_nxt = S_CLEAR;
                     we_nxt    = 1'b1;
                     add_nxt   = 2'd0;
                  end
               endcase
            end
         end
         S_WRITE: begin
            state_nxt     = S_RESP;
            rsp_valid_nxt = 1'b1;
         end
         S_READ: begin
            state_nxt     = S_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = bus.read_data;
         end
         S_START: begin
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
         end
         S_WAIT: begin
            cnt_nxt = cnt_q + CNT_W'(1);
            // alu_done takes priority over an expiring timeout
            if (bus.alu_done) begin
               state_nxt = S_CAPTURE;
               sel_nxt   = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_nxt     = S_RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
            end
         end
         S_CAPTURE: begin
            state_nxt     = S_RESP;
            rsp_valid_nxt = 1'b1;
         end
         S_CLEAR: begin
            if (add_q == 2'd3) begin
               state_nxt     = S_RESP;
               rsp_valid_nxt = 1'b1;
            end else begin
               we_nxt  = 1'b1;
               add_nxt = add_q + 2'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_nxt = S_IDLE;
            end else begin
               rsp_valid_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.cmd_ready = (state == S_IDLE) && !rst;
   assign bus.we        = we_q;
   assign bus.re        = re_q;
   assign bus.select    = sel_q;
   assign bus.alu_start = start_q;
   assign bus.add       = add_q;
   assign bus.wdata     = wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Randomized bench for reg_sequencer: a register file and delayed multiplier drive the DUT,
// and a transaction-level model of the four registers predicts every response.
module tb_reg_sequencer;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_sequencer_if #(.DATA_W(DW)) bus ();

   reg_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Environment: register file and multiplier with a programmable done delay (0 = never)
   logic [DW-1:0]   regs [4] = '{default: '0};
   logic [2*DW-1:0] prod = '0;
   logic            armed = 1'b0;
   int              dcnt = 0;
   int              done_delay = 0;

   assign bus.read_data = regs[bus.add];
   assign bus.alu_done  = armed && (dcnt == 0);

   always @(posedge clk) begin
      if (bus.we) regs[bus.add] <= bus.wdata;
      if (bus.select) begin
         regs[2] <= prod[DW-1:0];
         regs[3] <= prod[2*DW-1:DW];
      end
      if (bus.alu_start) prod <= (2*DW)'(regs[0]) * (2*DW)'(regs[1]);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
         dcnt  <= 0;
      end else if (bus.alu_start) begin
         armed <= (done_delay != 0);
         dcnt  <= done_delay - 1;
      end else if (armed) begin
         if (dcnt == 0) armed <= 1'b0;
         else dcnt <= dcnt - 1;
      end
   end

   // Reference model of register contents
   logic [DW-1:0] mdl [4] = '{default: '0};

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [DW-1:0] data,
                          input int delay, input int hold);
      int              cyc, n_we, n_re, n_sel, n_st, n_clr, exp_lat;
      logic [DW-1:0]   exp_data;
      logic            exp_err;
      logic [2*DW-1:0] p;
      exp_data = '0;
      exp_err  = 1'b0;
      exp_lat  = 2;
      case (op)
         2'd0: mdl[addr] = data;
         2'd1: exp_data = mdl[addr];
         2'd2: begin
            if (delay >= 1 && delay <= int'(TO)) begin
               p = (2*DW)'(mdl[0]) * (2*DW)'(mdl[1]);
               mdl[2]  = p[DW-1:0];
               mdl[3]  = p[2*DW-1:DW];
               exp_lat = delay + 3;
            end else begin
               exp_err = 1'b1;
               exp_lat = int'(TO) + 2;
            end
         end
         default: begin
            mdl     = '{default: '0};
            exp_lat = 5;
         end
      endcase

      done_delay    = delay;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = data;
      bus.cmd_valid = 1'b1;
      chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      cyc = 1; n_we = 0; n_re = 0; n_sel = 0; n_st = 0; n_clr = 0;
      while (!bus.rsp_valid && cyc < 100) begin
         n_we  += int'(bus.we);
         n_re  += int'(bus.re);
         n_sel += int'(bus.select);
         n_st  += int'(bus.alu_start);
         if (bus.we && op == 2'd3) begin
            chk("clr_add", 64'(bus.add), 64'(n_clr));
            chk("clr_wdata", 64'(bus.wdata), 64'd0);
            n_clr++;
         end
         if (bus.we && op == 2'd0) begin
            chk("wr_add", 64'(bus.add), 64'(addr));
            chk("wr_wdata", 64'(bus.wdata), 64'(data));
         end
         if (bus.re) chk("rd_add", 64'(bus.add), 64'(addr));
         if (!bus.we) chk("wdata_zero", 64'(bus.wdata), 64'd0);
         chk("excl", 64'((int'(bus.we) + int'(bus.re) + int'(bus.select)) <= 1), 64'd1);
         @(negedge clk);
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(exp_lat));
      chk("n_we", 64'(n_we), (op == 2'd0) ? 64'd1 : (op == 2'd3) ? 64'd4 : 64'd0);
      chk("n_re", 64'(n_re), (op == 2'd1) ? 64'd1 : 64'd0);
      chk("n_sel", 64'(n_sel), (op == 2'd2 && !exp_err) ? 64'd1 : 64'd0);
      chk("n_start", 64'(n_st), (op == 2'd2) ? 64'd1 : 64'd0);
      chk("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
      chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
         chk("hold_data", 64'(bus.rsp_data), 64'(exp_data));
         chk("hold_err", 64'(bus.rsp_err), 64'(exp_err));
         chk("resp_strobes", 64'({bus.we, bus.re, bus.select, bus.alu_start}), 64'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("rsp_released", 64'(bus.rsp_valid), 64'd0);
      chk("ready_back", 64'(bus.cmd_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
      chk({tag, "_strobes"}, 64'({bus.we, bus.re, bus.select, bus.alu_start}), 64'd0);
      chk({tag, "_add"}, 64'(bus.add), 64'd0);
      chk({tag, "_wdata"}, 64'(bus.wdata), 64'd0);
      chk({tag, "_rsp"}, 64'({bus.rsp_valid, bus.rsp_err}), 64'd0);
      chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
   endtask

   // Reset asserted during the second CLEAR cycle; only register 0 has been cleared
   task automatic reset_mid_clear();
      done_delay    = 0;
      bus.cmd_op    = 2'd3;
      bus.cmd_addr  = 2'd0;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("clr1_we", 64'({bus.we, bus.add}), 64'({1'b1, 2'd0}));
      @(posedge clk);
      #2;
      chk("clr2_we", 64'({bus.we, bus.add}), 64'({1'b1, 2'd1}));
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      mdl[0] = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_ready", 64'(bus.cmd_ready), 64'd1);
      chk("postrst_we", 64'(bus.we), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]    op, addr;
      logic [DW-1:0] data;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_addr  = 2'd0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

      run_cmd(2'd0, 2'd1, 32'hABCD, 0, 0);
      run_cmd(2'd0, 2'd2, 32'h1234, 0, 0);
      run_cmd(2'd1, 2'd2, '0, 0, 2);
      run_cmd(2'd0, 2'd0, 32'h8000_0003, 0, 0);
      run_cmd(2'd2, 2'd0, '0, 5, 0);
      run_cmd(2'd0, 2'd1, 32'hFFFF_FFFF, 0, 1);
      run_cmd(2'd2, 2'd0, '0, int'(TO), 0);
      run_cmd(2'd1, 2'd3, '0, 0, 0);
      run_cmd(2'd2, 2'd0, '0, 0, 1);
      run_cmd(2'd2, 2'd0, '0, int'(TO) + 1, 0);
      run_cmd(2'd2, 2'd0, '0, 1, 0);
      run_cmd(2'd1, 2'd2, '0, 0, 0);
      run_cmd(2'd3, 2'd0, '0, 0, 3);
      run_cmd(2'd1, 2'd1, '0, 0, 0);

      for (int i = 0; i < 4; i++) run_cmd(2'd0, 2'(i), $urandom, 0, 0);
      reset_mid_clear();
      for (int i = 0; i < 4; i++) run_cmd(2'd1, 2'(i), '0, 0, 0);

      for (int i = 0; i < 150; i++) begin
         op   = 2'($urandom_range(0, 3));
         addr = 2'($urandom_range(0, 3));
         data = $urandom;
         run_cmd(op, addr, data, $urandom_range(0, int'(TO) + 1), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
